// File: rtl/stage_instruction_fetch_decode_buffer.sv
// Fetch-to-decode pipeline register with a two-entry skid buffer.
// A decode stall never drops a fetched instruction, and o_Ready is fully registered.
module stage_instruction_fetch_decode_buffer #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] NOP_WORD = 'h00000013
) (
  input  logic            i_Clock,
  input  logic            i_Reset,
  input  logic            i_Flush,
  input  logic            i_Valid,
  output logic            o_Ready,
  input  logic [XLEN-1:0] i_PC,
  input  logic [XLEN-1:0] i_NextPC,
  input  logic [XLEN-1:0] i_InstructionWord,
  input  logic            i_InstructionAddressMisaligned,
  output logic            o_Valid,
  input  logic            i_Ready,
  output logic [XLEN-1:0] o_PC,
  output logic [XLEN-1:0] o_NextPC,
  output logic [XLEN-1:0] o_InstructionWord,
  output logic            o_InstructionAddressMisaligned
);

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_HALF,
    ST_FULL
  } state_t;

  state_t state_reg, state_next;
  logic   ready_reg;

  logic [XLEN-1:0] main_pc_reg, main_npc_reg, main_word_reg;
  logic            main_mis_reg;
  logic [XLEN-1:0] skid_pc_reg, skid_npc_reg, skid_word_reg;
  logic            skid_mis_reg;

  logic in_fire, out_fire;
  logic load_main_in, load_main_skid, clear_main;
  logic load_skid, clear_skid;

  logic [XLEN-1:0] cap_word;

  assign o_Valid  = (state_reg != ST_EMPTY);
  assign o_Ready  = ready_reg;
  assign in_fire  = i_Valid & ready_reg;
  assign out_fire = o_Valid & i_Ready;

  // Misaligned fetches become NOP bubbles that still carry their PC and the exception tag
  assign cap_word = i_InstructionAddressMisaligned ? NOP_WORD : i_InstructionWord;

  assign o_PC                           = main_pc_reg;
  assign o_NextPC                       = main_npc_reg;
  assign o_InstructionWord              = main_word_reg;
  assign o_InstructionAddressMisaligned = main_mis_reg;

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      state_reg <= ST_EMPTY;
      ready_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != ST_FULL);
    end
  end

  always_comb begin
    state_next     = state_reg;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    load_skid      = 1'b0;
    clear_skid     = 1'b0;
    if (i_Flush) begin
      state_next = ST_EMPTY;
      clear_main = 1'b1;
      clear_skid = 1'b1;
    end else begin
      case (state_reg)
        ST_EMPTY: begin
          if (in_fire) begin
            load_main_in = 1'b1;
            state_next   = ST_HALF;
          end
        end
        ST_HALF: begin
          if (in_fire && out_fire) begin
            load_main_in = 1'b1;
          end else if (in_fire) begin
            load_skid  = 1'b1;
            state_next = ST_FULL;
          end else if (out_fire) begin
            clear_main = 1'b1;
            state_next = ST_EMPTY;
          end
        end
        ST_FULL: begin
          // Skid entry is always the older one, so it moves up before any new accept
          if (out_fire) begin
            load_main_skid = 1'b1;
            clear_skid     = 1'b1;
            state_next     = ST_HALF;
          end
        end
        default: begin
          state_next = ST_EMPTY;
          clear_main = 1'b1;
          clear_skid = 1'b1;
        end
      endcase
    end
  end

  // Main entry returns to bubble values whenever it empties, so no stale payload leaks out
  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      main_pc_reg   <= '0;
      main_npc_reg  <= '0;
      main_word_reg <= NOP_WORD;
      main_mis_reg  <= 1'b0;
    end else if (clear_main) begin
      main_pc_reg   <= '0;
      main_npc_reg  <= '0;
      main_word_reg <= NOP_WORD;
      main_mis_reg  <= 1'b0;
    end else if (load_main_skid) begin
      main_pc_reg   <= skid_pc_reg;
      main_npc_reg  <= skid_npc_reg;
      main_word_reg <= skid_word_reg;
      main_mis_reg  <= skid_mis_reg;
    end else if (load_main_in) begin
      main_pc_reg   <= i_PC;
      main_npc_reg  <= i_NextPC;
      main_word_reg <= cap_word;
      main_mis_reg  <= i_InstructionAddressMisaligned;
    end
  end

  always_ff @(posedge i_Clock or negedge i_Reset) begin
    if (!i_Reset) begin
      skid_pc_reg   <= '0;
      skid_npc_reg  <= '0;
      skid_word_reg <= NOP_WORD;
      skid_mis_reg  <= 1'b0;
    end else if (clear_skid) begin
      skid_pc_reg   <= '0;
      skid_npc_reg  <= '0;
      skid_word_reg <= NOP_WORD;
      skid_mis_reg  <= 1'b0;
    end else if (load_skid) begin
      skid_pc_reg   <= i_PC;
      skid_npc_reg  <= i_NextPC;
      skid_word_reg <= cap_word;
      skid_mis_reg  <= i_InstructionAddressMisaligned;
    end
  end

endmodule

// File: tb/tb_stage_instruction_fetch_decode_buffer.sv
// Directed and randomized bench for the fetch/decode skid buffer.
module tb_stage_instruction_fetch_decode_buffer;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        i_Clock = 1'b0;
  logic        i_Reset = 1'b0;
  logic        i_Flush = 1'b0;
  logic        i_Valid = 1'b0;
  logic        o_Ready;
  logic [31:0] i_PC = '0;
  logic [31:0] i_NextPC = '0;
  logic [31:0] i_InstructionWord = '0;
  logic        i_InstructionAddressMisaligned = 1'b0;
  logic        o_Valid;
  logic        i_Ready = 1'b0;
  logic [31:0] o_PC;
  logic [31:0] o_NextPC;
  logic [31:0] o_InstructionWord;
  logic        o_InstructionAddressMisaligned;

  int checks = 0;
  int failures = 0;

  stage_instruction_fetch_decode_buffer #(
    .XLEN(32),
    .NOP_WORD(32'h00000013)
  ) dut (
    .i_Clock(i_Clock),
    .i_Reset(i_Reset),
    .i_Flush(i_Flush),
    .i_Valid(i_Valid),
    .o_Ready(o_Ready),
    .i_PC(i_PC),
    .i_NextPC(i_NextPC),
    .i_InstructionWord(i_InstructionWord),
    .i_InstructionAddressMisaligned(i_InstructionAddressMisaligned),
    .o_Valid(o_Valid),
    .i_Ready(i_Ready),
    .o_PC(o_PC),
    .o_NextPC(o_NextPC),
    .o_InstructionWord(o_InstructionWord),
    .o_InstructionAddressMisaligned(o_InstructionAddressMisaligned)
  );

  always #5 i_Clock = ~i_Clock;

  task automatic cycle();
    @(posedge i_Clock);
    @(negedge i_Clock);
  endtask

  task automatic drive(input logic v, input logic [31:0] pc, input logic mis);
    i_Valid = v;
    i_PC = pc;
    i_NextPC = pc + 32'd4;
    i_InstructionWord = 32'h1000_0000 | pc;
    i_InstructionAddressMisaligned = mis;
  endtask

  task automatic test_reset();
    i_Reset = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    i_Ready = 1'b0;
    i_Flush = 1'b0;
    cycle();
    cycle();
    checks++;
    if (o_Valid !== 1'b0 || o_Ready !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got valid=%b ready=%b exp valid=0 ready=0", o_Valid, o_Ready);
    end
    checks++;
    if (o_PC !== 32'h0 || o_NextPC !== 32'h0 || o_InstructionWord !== NOP || o_InstructionAddressMisaligned !== 1'b0) begin
      failures++;
      $display("FAIL reset_payload got pc=%h npc=%h w=%h m=%b exp 0/0/%h/0", o_PC, o_NextPC, o_InstructionWord, o_InstructionAddressMisaligned, NOP);
    end
    i_Reset = 1'b1;
    cycle();
    checks++;
    if (o_Ready !== 1'b1 || o_Valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release got ready=%b valid=%b exp ready=1 valid=0", o_Ready, o_Valid);
    end
    $display("reset: released, ready=%b", o_Ready);
  endtask

  task automatic test_stream();
    logic [31:0] pcs [3];
    pcs[0] = 32'h00; pcs[1] = 32'h04; pcs[2] = 32'h08;
    i_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, pcs[k], 1'b0);
      cycle();
      checks++;
      if (o_Valid !== 1'b1 || o_PC !== pcs[k] || o_NextPC !== pcs[k] + 32'd4 || o_InstructionWord !== (32'h1000_0000 | pcs[k])) begin
        failures++;
        $display("FAIL stream_%0d got v=%b pc=%h npc=%h w=%h exp v=1 pc=%h", k, o_Valid, o_PC, o_NextPC, o_InstructionWord, pcs[k]);
      end
      checks++;
      if (o_Ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready_%0d got %b exp 1", k, o_Ready);
      end
      $display("stream: offered pc=%h", o_PC);
    end
    drive(1'b0, 32'h0, 1'b0);
    cycle();
    checks++;
    if (o_Valid !== 1'b0 || o_PC !== 32'h0 || o_InstructionWord !== NOP) begin
      failures++;
      $display("FAIL stream_drain got v=%b pc=%h w=%h exp v=0 pc=0 w=%h", o_Valid, o_PC, o_InstructionWord, NOP);
    end
  endtask

  task automatic test_stall();
    i_Ready = 1'b0;
    drive(1'b1, 32'h10, 1'b0);
    cycle();
    drive(1'b1, 32'h14, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (o_Ready !== 1'b0 || o_Valid !== 1'b1 || o_PC !== 32'h10) begin
      failures++;
      $display("FAIL stall_full got ready=%b v=%b pc=%h exp ready=0 v=1 pc=10", o_Ready, o_Valid, o_PC);
    end
    cycle();
    checks++;
    if (o_PC !== 32'h10 || o_InstructionWord !== 32'h1000_0010 || o_Ready !== 1'b0) begin
      failures++;
      $display("FAIL stall_hold got pc=%h w=%h ready=%b exp pc=10 w=10000010 ready=0", o_PC, o_InstructionWord, o_Ready);
    end
    i_Ready = 1'b1;
    $display("stall: delivered pc=%h", o_PC);
    cycle();
    checks++;
    if (o_PC !== 32'h14 || o_Valid !== 1'b1 || o_Ready !== 1'b1 || o_NextPC !== 32'h18) begin
      failures++;
      $display("FAIL stall_second got pc=%h v=%b ready=%b npc=%h exp pc=14 v=1 ready=1 npc=18", o_PC, o_Valid, o_Ready, o_NextPC);
    end
    $display("stall: delivered pc=%h", o_PC);
    cycle();
    checks++;
    if (o_Valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_empty got v=%b exp 0", o_Valid);
    end
  endtask

  task automatic test_misaligned();
    i_Ready = 1'b0;
    drive(1'b1, 32'h22, 1'b1);
    i_InstructionWord = 32'hDEADBEEF;
    cycle();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (o_InstructionWord !== NOP || o_InstructionAddressMisaligned !== 1'b1 || o_PC !== 32'h22 || o_NextPC !== 32'h26) begin
      failures++;
      $display("FAIL misaligned got w=%h m=%b pc=%h npc=%h exp w=%h m=1 pc=22 npc=26", o_InstructionWord, o_InstructionAddressMisaligned, o_PC, o_NextPC, NOP);
    end
    $display("misaligned: offered pc=%h w=%h", o_PC, o_InstructionWord);
    i_Ready = 1'b1;
    cycle();
    checks++;
    if (o_InstructionAddressMisaligned !== 1'b0 || o_Valid !== 1'b0) begin
      failures++;
      $display("FAIL misaligned_clear got m=%b v=%b exp m=0 v=0", o_InstructionAddressMisaligned, o_Valid);
    end
  endtask

  task automatic test_flush();
    i_Ready = 1'b0;
    drive(1'b1, 32'h30, 1'b0);
    cycle();
    drive(1'b1, 32'h34, 1'b0);
    cycle();
    drive(1'b1, 32'h38, 1'b0);
    i_Flush = 1'b1;
    cycle();
    i_Flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (o_Valid !== 1'b0 || o_InstructionWord !== NOP || o_Ready !== 1'b1 || o_PC !== 32'h0) begin
      failures++;
      $display("FAIL flush_full got v=%b w=%h ready=%b pc=%h exp v=0 w=%h ready=1 pc=0", o_Valid, o_InstructionWord, o_Ready, o_PC, NOP);
    end
    i_Ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      cycle();
      checks++;
      if (o_Valid !== 1'b0) begin
        failures++;
        $display("FAIL flush_ghost_%0d got v=%b pc=%h exp v=0", k, o_Valid, o_PC);
      end
    end
    // flush from HALF while a new instruction fires in: input must be dropped
    i_Ready = 1'b0;
    drive(1'b1, 32'h40, 1'b0);
    cycle();
    drive(1'b1, 32'h44, 1'b0);
    i_Flush = 1'b1;
    cycle();
    i_Flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (o_Valid !== 1'b0 || o_PC !== 32'h0) begin
      failures++;
      $display("FAIL flush_half got v=%b pc=%h exp v=0 pc=0", o_Valid, o_PC);
    end
    $display("flush: buffer emptied, ready=%b", o_Ready);
  endtask

  task automatic test_async_reset();
    i_Ready = 1'b0;
    drive(1'b1, 32'h50, 1'b0);
    cycle();
    drive(1'b1, 32'h54, 1'b0);
    cycle();
    drive(1'b0, 32'h0, 1'b0);
    #2 i_Reset = 1'b0;
    #1;
    checks++;
    if (o_Valid !== 1'b0 || o_Ready !== 1'b0 || o_PC !== 32'h0 || o_NextPC !== 32'h0 || o_InstructionWord !== NOP) begin
      failures++;
      $display("FAIL async_reset got v=%b ready=%b pc=%h npc=%h w=%h exp 0/0/0/0/%h", o_Valid, o_Ready, o_PC, o_NextPC, o_InstructionWord, NOP);
    end
    @(negedge i_Clock);
    i_Reset = 1'b1;
    i_Ready = 1'b1;
    drive(1'b1, 32'h100, 1'b0);
    cycle();
    checks++;
    if (o_Valid !== 1'b0 || o_Ready !== 1'b1) begin
      failures++;
      $display("FAIL async_release got v=%b ready=%b exp v=0 ready=1", o_Valid, o_Ready);
    end
    cycle();
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (o_Valid !== 1'b1 || o_PC !== 32'h100) begin
      failures++;
      $display("FAIL async_first got v=%b pc=%h exp v=1 pc=100", o_Valid, o_PC);
    end
    $display("async_reset: first after release pc=%h", o_PC);
    cycle();
    checks++;
    if (o_Valid !== 1'b0) begin
      failures++;
      $display("FAIL async_drain got v=%b exp 0", o_Valid);
    end
  endtask

  task automatic test_random();
    logic [95:0] q[$];
    logic [31:0] next_pc = 32'h1000;
    int          fetched = 0;
    int          cyc = 0;
    logic        v, r, f, in_fire, out_fire;
    logic        stall_prev = 1'b0;
    logic [31:0] held_pc = '0, held_npc = '0, held_w = '0;
    logic [95:0] exp_entry;
    while (cyc < 20000 && (fetched < 1000 || q.size() != 0)) begin
      checks++;
      if (o_Valid !== (q.size() != 0) || o_Ready !== (q.size() < 2)) begin
        failures++;
        $display("FAIL rand_hs cyc=%0d got v=%b ready=%b exp occupancy=%0d", cyc, o_Valid, o_Ready, q.size());
      end
      if (q.size() == 0) begin
        checks++;
        if (o_PC !== 32'h0 || o_InstructionWord !== NOP) begin
          failures++;
          $display("FAIL rand_bubble cyc=%0d got pc=%h w=%h exp pc=0 w=%h", cyc, o_PC, o_InstructionWord, NOP);
        end
      end
      if (stall_prev) begin
        checks++;
        if (o_PC !== held_pc || o_NextPC !== held_npc || o_InstructionWord !== held_w) begin
          failures++;
          $display("FAIL rand_stable cyc=%0d got pc=%h exp pc=%h", cyc, o_PC, held_pc);
        end
      end
      f = (fetched < 1000) && ($urandom_range(0, 19) == 0);
      v = (fetched < 1000) && ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 1) == 1);
      drive(v, next_pc, 1'b0);
      i_InstructionWord = next_pc ^ 32'h5A5A_0000;
      i_Ready = r;
      i_Flush = f;
      in_fire = v & o_Ready;
      out_fire = o_Valid & r;
      if (out_fire) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rand_extra cyc=%0d got pc=%h exp no delivery", cyc, o_PC);
        end else begin
          exp_entry = q.pop_front();
          checks++;
          if ({o_PC, o_NextPC, o_InstructionWord} !== exp_entry) begin
            failures++;
            $display("FAIL rand_order cyc=%0d got pc=%h npc=%h w=%h exp pc=%h npc=%h w=%h", cyc, o_PC, o_NextPC, o_InstructionWord, exp_entry[95:64], exp_entry[63:32], exp_entry[31:0]);
          end
          $display("random: delivered pc=%h", o_PC);
        end
      end
      if (f) begin
        q.delete();
      end else if (in_fire) begin
        q.push_back({next_pc, next_pc + 32'd4, next_pc ^ 32'h5A5A_0000});
      end
      if (in_fire) begin
        fetched++;
        next_pc = next_pc + 32'd4;
      end
      stall_prev = o_Valid & ~r & ~f;
      held_pc = o_PC;
      held_npc = o_NextPC;
      held_w = o_InstructionWord;
      cycle();
      cyc++;
    end
    i_Flush = 1'b0;
    drive(1'b0, 32'h0, 1'b0);
    checks++;
    if (cyc >= 20000) begin
      failures++;
      $display("FAIL rand_timeout got fetched=%0d pending=%0d exp completion", fetched, q.size());
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_misaligned();
    test_flush();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stage_instruction_fetch_decode_buffer.md
Name: stage_instruction_fetch_decode_buffer

Overview:
Pipeline boundary between the instruction fetch stage and the instruction decode stage. It registers the fetched PC, next-PC, instruction word and misaligned-address flag. It provides a valid/ready handshake on both sides, using a two-entry skid buffer so that a decode stall never loses a fetched instruction. It supports a flush for branch/jump redirects and tags misaligned fetches as NOP bubbles carrying an exception flag.

Parameters:
XLEN, 32, width of PC, next-PC and instruction word
NOP_WORD, 32'h00000013, instruction word driven for bubbles and misaligned fetches (addi x0,x0,0)

Ports:
i_Clock  input  1  clock; all state updates on the rising edge
i_Reset  input  1  asynchronous, active-low reset
i_Flush  input  1  discard all buffered and incoming instructions (redirect)
i_Valid  input  1  fetch side presents an instruction this cycle
o_Ready  output  1  buffer can accept an instruction this cycle
i_PC  input  XLEN  PC of the presented instruction
i_NextPC  input  XLEN  sequential next PC from fetch
i_InstructionWord  input  XLEN  fetched instruction word
i_InstructionAddressMisaligned  input  1  fetch address misaligned
o_Valid  output  1  decode side is offered an instruction
i_Ready  input  1  decode accepts the offered instruction
o_PC  output  XLEN  PC of the offered instruction
o_NextPC  output  XLEN  next PC of the offered instruction
o_InstructionWord  output  XLEN  offered instruction word (NOP_WORD if misaligned)
o_InstructionAddressMisaligned  output  1  exception tag for the offered instruction

Behaviour:
- Handshake signals:
  - in_fire = i_Valid & o_Ready
  - out_fire = o_Valid & i_Ready
  - A transaction completes on the rising edge where fire is high.
- Storage:
  - main register: drives the outputs.
  - skid register: holds an instruction accepted while decode stalled.
- State machine (reset: EMPTY):
  - EMPTY: o_Valid=0. in_fire -> load main, go to HALF.
  - HALF: o_Valid=1.
    - in_fire & out_fire -> main <= input, stay HALF.
    - in_fire only -> skid <= input, go to FULL.
    - out_fire only -> go to EMPTY.
    - neither -> hold.
  - FULL: o_Valid=1, o_Ready=0.
    - out_fire -> main <= skid, go to HALF.
    - otherwise hold.
- o_Ready is registered: o_Ready = (next state != FULL) and reset not active.
  - It is 0 while reset is asserted.
  - It becomes 1 on the first rising edge after reset release.
  - It is never a combinational function of i_Ready (no ready path through the block).
- Latency: an instruction accepted at edge N is offered on o_Valid after edge N (1 cycle). Zero-bubble throughput when i_Valid=i_Ready=1 continuously.
- Ordering: strict FIFO. The skid entry is always older than any newly accepted instruction.
- Misaligned capture: when the accepted input has i_InstructionAddressMisaligned=1:
  - the stored word is NOP_WORD;
  - the flag is stored as 1;
  - PC and next-PC are stored unchanged.
- Flush (highest priority):
  - i_Flush=1 at an edge sends the state to EMPTY.
  - Both entries are invalidated.
  - The input is discarded even if in_fire.
  - The payload goes to the bubble values: PC 0, next-PC 0, word NOP_WORD, flag 0.
  - o_Ready=1 on the following cycle.
  - If flush coincides with out_fire, the downstream transfer still counts as completed; decode is responsible for ignoring it.
- Reset (asynchronous, any time including mid-transfer):
  - Immediately: o_Valid=0, o_Ready=0, state EMPTY.
  - o_PC=0, o_NextPC=0, o_InstructionWord=NOP_WORD, o_InstructionAddressMisaligned=0.
  - Skid contents are cleared.
- Output payload while o_Valid=0 equals the bubble values. It must not leak stale data.
- While o_Valid=1 and i_Ready=0, all outputs are held stable.

Test Plan:
- Reset release, then i_Valid=1 with PC=0x00,0x04,0x08 and i_Ready=1 held -> o_Valid high one cycle after each acceptance, o_PC sequence 0x00,0x04,0x08 with no bubbles, o_Ready constantly 1.
- Accept PC=0x10 then 0x14 with i_Ready=0 -> state FULL, o_Ready=0, o_PC held 0x10. Raise i_Ready -> 0x10 then 0x14 delivered in order, o_Ready returns 1 after the first out_fire.
- Fetch PC=0x22 with misaligned=1, word 0xDEADBEEF -> o_InstructionWord=0x00000013, o_InstructionAddressMisaligned=1, o_PC=0x22, o_NextPC passed through.
- FULL state (0x30, 0x34 buffered) and i_Flush=1 with i_Valid=1 PC=0x38 -> next cycle o_Valid=0, o_InstructionWord=0x00000013, o_Ready=1. 0x30, 0x34 and 0x38 are never delivered.
- Assert i_Reset low asynchronously between edges while FULL -> outputs go to reset values before the next edge. After release, the first accepted PC=0x100 is delivered with no stale entry preceding it.
- Random i_Valid/i_Ready at 50% each over 1000 instructions, with flushes at 5% -> scoreboard confirms:
  - in-order delivery;
  - no loss or duplication between flushes;
  - outputs stable during stalls.
